serial_deser: RTL and testbench
===============================

// Module: serial_deser
// PURPOSE
//  Serial-in/parallel-out deserializer; the capture end for words a shift register streams out SHIFT bits per beat.
//  Collects N/SHIFT beats of ser_in into a word and presents it on a registered output with valid/ready handshake.
//  One-word output buffer: the next word is collected while the current word waits to be consumed.
// PARAMETERS
//  N      8  word width in bits; N % SHIFT == 0 required (elaboration $error otherwise)
//  SHIFT  1  bits accepted per beat
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  sys_rst_n  in   1        asynchronous active-low reset
//  enable     in   1        1: beats accepted; 0: shift reg + beat counter frozen (output handshake still live)
//  clear      in   1        synchronous clear, same effect as reset
//  msb_first  in   1        1: first beat lands in MSBs; 0: first beat lands in LSBs; sampled on first beat of a word
//  ser_in     in   SHIFT    beat data
//  ser_valid  in   1        beat accepted on a cycle with enable && ser_valid
//  out_data   out  N        completed word (registered)
//  out_valid  out  1        out_data holds an unconsumed word
//  out_ready  in   1        consumer accepts out_data when out_valid && out_ready
//  busy       out  1        word collection in progress (FSM != IDLE)
//  overrun    out  1        sticky: a completed word was dropped; cleared only by reset/clear
//  parity_err out  1        parity result for out_data (tied 0 unless SERIAL_DESER_PARITY_EN)
// BEHAVIOUR
//  - Reset/clear: FSM=IDLE, shift reg=0, beat count=0, out_data=0, out_valid=0, overrun=0, parity_err=0.
//  - FSM: IDLE -(accepted beat)-> SHIFT; SHIFT -(beat N/SHIFT accepted)-> IDLE (or PARITY with macro);
//    PARITY -(accepted beat)-> IDLE. A word of exactly one beat (N==SHIFT) goes IDLE->IDLE.
//  - msb_first=1: sreg <= {sreg[N-SHIFT-1:0], ser_in}; msb_first=0: sreg <= {ser_in, sreg[N-1:SHIFT]}.
//    Latched msb_first held for whole word; changes mid-word are ignored.
//  - Latency: word completes on cycle t (last beat accepted) -> out_data/out_valid valid at t+1.
//  - Transfer to output when complete and (!out_valid || out_ready): out_data <= assembled word, out_valid stays/becomes 1.
//  - Consume without completion same cycle: out_valid <= 0, out_data retained.
//  - Completion while out_valid && !out_ready: new word dropped, out_data unchanged, overrun <= 1.
//  - Completion same cycle as consume: new word loaded, out_valid remains 1, no overrun.
//  - Beat count wraps to 0 after each word; no partial-word flush. enable=0 mid-word pauses, resumes on same beat.
//  - Reset or clear mid-word discards partial word and any buffered word.
// CONFIGURATION
//  SERIAL_DESER_PARITY_EN defined: after the N/SHIFT data beats one extra parity beat (PARITY state) is required;
//    ser_in[0] is the even-parity bit, other bits ignored. Word transfers when parity beat accepted;
//    parity_err = (^word ^ ser_in[0]), registered with out_data, same transfer/overrun rules.
//  Not defined: no PARITY state, word completes on last data beat, parity_err tied 0.
// TESTING (N=8, SHIFT=1 unless noted)
//  1. msb_first=1, beats 1,0,1,1,0,0,1,0, out_ready=1 -> out_data=8'hB2, out_valid=1 exactly one cycle after beat 8.
//  2. msb_first=0, same beats -> out_data=8'h4D; busy=1 from beat 1 to beat 8, 0 afterwards.
//  3. out_ready=0, send two words 8'hB2 then 8'h4D -> out_data stays 8'hB2, overrun=1 sticky; out_ready=1 -> out_valid=0.
//  4. out_ready pulsed on the cycle word 2 completes -> out_valid stays 1, out_data=8'h4D, overrun=0.
//  5. sys_rst_n low after 3 beats, then 8 beats of 8'hFF -> all outputs 0 during reset; next word 8'hFF (no stale bits).
//  6. enable=0 for 5 cycles with ser_valid=1 mid-word -> no beats counted; with macro, 8'hB2 + parity 1 -> parity_err=1.

Source files
------------

// File: rtl/serial_deser_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_deser_if
//  Purpose  : Bundles the serial beat input and the parallel word output
//             handshake of serial_deser.
//  Signals  : ser_in    [SHIFT-1:0] beat data
//             ser_valid             beat offered
//             out_data  [N-1:0]     completed word
//             out_valid             out_data holds an unconsumed word
//             out_ready             consumer accepts out_data
//  Modports : slave  - deserializer side (takes beats, offers words)
//             master - surrounding logic (offers beats, takes words)
//  Revision : 1.0  initial release
// ============================================================================
interface serial_deser_if #(
  parameter int N     = 8,
  parameter int SHIFT = 1
);
  logic [SHIFT-1:0] ser_in;
  logic             ser_valid;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  ser_in,
    input  ser_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport master (
    output ser_in,
    output ser_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );
endinterface
`default_nettype wire

// File: rtl/serial_deser.sv
`default_nettype none
// ============================================================================
//  Module   : serial_deser
//  Purpose  : Serial-in / parallel-out deserializer. Collects N/SHIFT beats
//             of SHIFT bits into an N-bit word and presents it on a
//             registered output with a one-word valid/ready buffer, so the
//             next word can be collected while the current one waits.
//  Ports    : clk        system clock (rising edge)
//             sys_rst_n  asynchronous active-low reset
//             enable     1: beats accepted, 0: collection frozen
//             clear      synchronous clear, same effect as reset
//             msb_first  bit order, sampled on the first beat of a word
//             bus        serial_deser_if.slave (beats in, words out)
//             busy       a word collection is in progress
//             overrun    sticky: a completed word was dropped
//             parity_err parity result registered alongside out_data
//  Config   : SERIAL_DESER_PARITY_EN - when defined, each word is followed by
//             one even-parity beat (ser_in[0]); otherwise parity_err is 0.
//  Revision : 1.0  initial release
// ============================================================================
module serial_deser #(
  parameter int N     = 8,
  parameter int SHIFT = 1
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               msb_first,
  serial_deser_if.slave      bus,
  output logic               busy,
  output logic               overrun,
  output logic               parity_err
);

  localparam int BEATS = N / SHIFT;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BEATS - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
`ifdef SERIAL_DESER_PARITY_EN
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_AFTER_DATA = c_PARITY;
`else
  localparam logic [1:0] c_AFTER_DATA = c_IDLE;
`endif

  generate
    if (SHIFT < 1 || (N % SHIFT) != 0) begin : g_cfg_check
      $error("serial_deser: N (%0d) must be a multiple of SHIFT (%0d)", N, SHIFT);
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_sreg;
  logic [N-1:0]     w_sreg_next;
  logic             r_msb;
  logic [N-1:0]     r_out_data;
  logic             r_out_valid;
  logic             r_overrun;

  logic             w_beat;
  logic             w_data_beat;
  logic             w_last;
  logic             w_msb;
  logic             w_complete;
  logic [N-1:0]     w_word;

  assign w_beat = enable && bus.ser_valid;
  // Bit order comes from the live input on a word's first beat, then from
  // the latched copy so mid-word changes have no effect.
  assign w_msb  = (r_state == c_IDLE) ? msb_first : r_msb;

`ifdef SERIAL_DESER_PARITY_EN
  logic r_parity_err;
  logic w_perr;
  assign w_data_beat = w_beat && (r_state != c_PARITY);
  // The assembled word already sits in r_sreg; the parity beat releases it.
  assign w_complete  = w_beat && (r_state == c_PARITY);
  assign w_word      = r_sreg;
  assign w_perr      = (^r_sreg) ^ bus.ser_in[0];
  assign parity_err  = r_parity_err;
`else
  assign w_data_beat = w_beat;
  assign w_complete  = w_last;
  assign w_word      = w_sreg_next;
  assign parity_err  = 1'b0;
`endif

  assign w_last = w_data_beat && (r_cnt == c_LAST);

  generate
    if (N == SHIFT) begin : g_one_beat
      assign w_sreg_next = bus.ser_in;
    end else begin : g_multi_beat
      assign w_sreg_next = w_msb ? {r_sreg[N-SHIFT-1:0], bus.ser_in}
                                 : {bus.ser_in, r_sreg[N-1:SHIFT]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE, c_SHIFT: begin
        if (w_data_beat) begin
          w_state_next = w_last ? c_AFTER_DATA : c_SHIFT;
        end
      end
`ifdef SERIAL_DESER_PARITY_EN
      c_PARITY: begin
        if (w_beat) begin
          w_state_next = c_IDLE;
        end
      end
`endif
      default: w_state_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_sreg       <= '0;
      r_msb        <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else if (clear) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_sreg       <= '0;
      r_msb        <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;

      if (w_data_beat) begin
        r_sreg <= w_sreg_next;
        r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (r_state == c_IDLE) begin
          r_msb <= msb_first;
        end
      end

      // One-word buffer: a finished word may replace the buffered one only
      // if that one is empty or being consumed this cycle; otherwise drop.
      if (w_complete) begin
        if (!r_out_valid || bus.out_ready) begin
          r_out_data   <= w_word;
          r_out_valid  <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
          r_parity_err <= w_perr;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign busy          = (r_state != c_IDLE);
  assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_deser
//  Purpose  : Self-checking bench for serial_deser (N=8, SHIFT=1). A
//             queue-based word model is compared against the DUT on every
//             falling edge; directed scenarios add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_deser;

  localparam int N     = 8;
  localparam int SHIFT = 1;
  localparam int BEATS = N / SHIFT;
`ifdef SERIAL_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sys_rst_n;
  logic enable;
  logic clear;
  logic msb_first;
  logic busy;
  logic overrun;
  logic parity_err;

  serial_deser_if #(.N(N), .SHIFT(SHIFT)) bus ();

  serial_deser #(.N(N), .SHIFT(SHIFT)) dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .clear      (clear),
    .msb_first  (msb_first),
    .bus        (bus),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [SHIFT-1:0] m_beats[$];
  bit               m_msb;
  logic [N-1:0]     m_data;
  bit               m_valid;
  bit               m_over;
  bit               m_perr;

  function automatic logic [N-1:0] assemble();
    logic [N-1:0] w = '0;
    for (int i = 0; i < m_beats.size(); i++) begin
      if (m_msb) w = (w << SHIFT) | N'(m_beats[i]);
      else       w = w | (N'(m_beats[i]) << (SHIFT * i));
    end
    return w;
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_msb   = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_step();
    bit           comp = 1'b0;
    bit           perr = 1'b0;
    logic [N-1:0] word = '0;
    if (enable && bus.ser_valid) begin
      if (PAR_EN && m_beats.size() == BEATS) begin
        word = assemble();
        perr = (^word) ^ bus.ser_in[0];
        comp = 1'b1;
        m_beats.delete();
      end else begin
        if (m_beats.size() == 0) m_msb = msb_first;
        m_beats.push_back(bus.ser_in);
        if (!PAR_EN && m_beats.size() == BEATS) begin
          word = assemble();
          comp = 1'b1;
          m_beats.delete();
        end
      end
    end
    if (comp) begin
      if (!m_valid || bus.out_ready) begin
        m_data  = word;
        m_valid = 1'b1;
        m_perr  = perr;
      end else begin
        m_over = 1'b1;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge sys_rst_n);
      if (!sys_rst_n || clear) model_reset();
      else                     model_step();
    end
  end

  // ---------------- every-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("out_data",   bus.out_data,  m_data);
      check("out_valid",  bus.out_valid, m_valid);
      check("overrun",    overrun,       m_over);
      check("busy",       busy,          (m_beats.size() != 0));
      check("parity_err", parity_err,    m_perr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit en, input bit sv, input logic [SHIFT-1:0] si,
                     input bit rdy, input bit msb);
    enable        = en;
    bus.ser_valid = sv;
    bus.ser_in    = si;
    bus.out_ready = rdy;
    msb_first     = msb;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit msb, input bit rdy,
                           input bit rdy_last);
    int idx;
    for (int i = 0; i < BEATS; i++) begin
      idx = msb ? (BEATS - 1 - i) : i;
      cyc(1'b1, 1'b1, w[idx*SHIFT +: SHIFT],
          (i == BEATS - 1 && !PAR_EN) ? rdy_last : rdy, msb);
    end
    if (PAR_EN) cyc(1'b1, 1'b1, SHIFT'(^w), rdy_last, msb);
  endtask

  logic [N-1:0] pat;

  initial begin
    sys_rst_n     = 1'b0;
    clear         = 1'b0;
    enable        = 1'b0;
    msb_first     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_in    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_busy",      busy,          0);
    check("rst_overrun",   overrun,       0);
    check("rst_parity",    parity_err,    0);
    sys_rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: MSB-first word
    send_word(8'hB2, 1'b1, 1'b1, 1'b1);
    check("t1_valid", bus.out_valid, 1);
    check("t1_data",  bus.out_data,  32'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_consumed", bus.out_valid, 0);

    // 2: LSB-first with the same beat sequence
    pat = 8'hB2;
    for (int i = 0; i < BEATS; i++) begin
      cyc(1'b1, 1'b1, pat[BEATS-1-i], 1'b1, 1'b0);
      if (i == 0) check("t2_busy_first", busy, 1);
      if (i == BEATS - 2) check("t2_valid_early", bus.out_valid, 0);
    end
`ifdef SERIAL_DESER_PARITY_EN
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    check("t2_busy_after", busy, 0);
    check("t2_valid", bus.out_valid, 1);
    check("t2_data",  bus.out_data,  32'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3: consumer stalled, second word dropped
    send_word(8'hB2, 1'b1, 1'b0, 1'b0);
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    check("t3_data",    bus.out_data,  32'hB2);
    check("t3_valid",   bus.out_valid, 1);
    check("t3_overrun", overrun,       1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_sticky", overrun, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_drained", bus.out_valid, 0);
    check("t3_sticky2", overrun, 1);
    clear = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    check("t3_cleared", overrun, 0);

    // 4: consume on the completion cycle of the next word
    send_word(8'hB2, 1'b1, 1'b0, 1'b0);
    check("t4_first", bus.out_valid, 1);
    send_word(8'h4D, 1'b0, 1'b0, 1'b1);
    check("t4_valid",   bus.out_valid, 1);
    check("t4_data",    bus.out_data,  32'h4D);
    check("t4_overrun", overrun,       0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_drained", bus.out_valid, 0);

    // 5: reset mid-word with a buffered word pending
    send_word(8'h5A, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_busy_pre", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_data",  bus.out_data,  0);
    check("t5_rst_busy",  busy,          0);
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    send_word(8'hFF, 1'b1, 1'b1, 1'b1);
    check("t5_data",  bus.out_data,  32'hFF);
    check("t5_valid", bus.out_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 6: enable low mid-word with ser_valid held high
    pat = 8'hB2;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, pat[BEATS-1-i], 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6_paused_busy", busy, 1);
    for (int i = 4; i < BEATS; i++) cyc(1'b1, 1'b1, pat[BEATS-1-i], 1'b1, 1'b1);
`ifdef SERIAL_DESER_PARITY_EN
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t6_parity_err", parity_err, 1);
`endif
    check("t6_data",  bus.out_data,  32'hB2);
    check("t6_valid", bus.out_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      clear = ($urandom_range(0, 149) == 0);
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
          SHIFT'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    clear = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
